// File: rtl/color_encoder_if.sv
// Handshake bundle between colour capture logic and the colour encoder.
interface color_encoder_if;
  logic [11:0] color_in;
  logic        color_valid;
  logic        color_ready;
  logic        clear;
  logic        code_ack;
  logic [7:0]  code_vec;
  logic        code_valid;
  logic [1:0]  fill_count;
  logic        bad_color;

  modport master (
    output color_in, color_valid, clear, code_ack,
    input  color_ready, code_vec, code_valid, fill_count, bad_color
  );

  modport slave (
    input  color_in, color_valid, clear, code_ack,
    output color_ready, code_vec, code_valid, fill_count, bad_color
  );
endinterface

// File: rtl/color_encoder.sv
// Maps 12-bit palette colours to 2-bit codes and packs four of them into an
// 8-bit sequence word; off-palette colours are dropped with a one-cycle pulse.
module color_encoder #(
  parameter logic [11:0] COLOR1 = 12'hF00,
  parameter logic [11:0] COLOR2 = 12'h0F0,
  parameter logic [11:0] COLOR3 = 12'h00F,
  parameter logic [11:0] COLOR4 = 12'hFF0
) (
  input  logic          clk,
  input  logic          reset,
  color_encoder_if.slave bus
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pack;
  logic [7:0] r_code_vec;
  logic       r_code_valid;
  logic       r_bad;
  logic [1:0] r_fill;

  logic       w_ready;
  logic       w_accept;
  logic       w_match;
  logic [1:0] w_code;

  assign w_ready  = (r_state == FILL);
  assign w_accept = bus.color_valid & w_ready & ~bus.clear;

  // Lowest-numbered palette entry wins if parameters are duplicated.
  always_comb begin
    w_match = 1'b1;
    w_code  = 2'd0;
    if      (bus.color_in == COLOR1) w_code = 2'd0;
    else if (bus.color_in == COLOR2) w_code = 2'd1;
    else if (bus.color_in == COLOR3) w_code = 2'd2;
    else if (bus.color_in == COLOR4) w_code = 2'd3;
    else                             w_match = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear)
      w_state_nxt = FILL;
    else if (r_state == HOLD && bus.code_ack)
      w_state_nxt = FILL;
    else if (w_accept && w_match && r_fill == 2'd3)
      w_state_nxt = HOLD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FILL;
      r_pack       <= 8'h00;
      r_code_vec   <= 8'h00;
      r_code_valid <= 1'b0;
      r_bad        <= 1'b0;
      r_fill       <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_bad   <= 1'b0;
      if (bus.clear) begin
        r_fill <= 2'd0;
        r_pack <= 8'h00;
        if (r_state == HOLD) r_code_valid <= 1'b0;
      end else if (r_state == HOLD) begin
        if (bus.code_ack) r_code_valid <= 1'b0;
      end else if (w_accept) begin
        if (!w_match) begin
          r_bad <= 1'b1;
        end else if (r_fill == 2'd3) begin
          // Slot 3 goes straight to the output; pack register starts over.
          r_code_vec   <= {w_code, r_pack[5:0]};
          r_code_valid <= 1'b1;
          r_fill       <= 2'd0;
          r_pack       <= 8'h00;
        end else begin
          r_pack[{r_fill, 1'b0} +: 2] <= w_code;
          r_fill                      <= r_fill + 2'd1;
        end
      end
    end
  end

  assign bus.color_ready = w_ready;
  assign bus.code_vec    = r_code_vec;
  assign bus.code_valid  = r_code_valid;
  assign bus.fill_count  = r_fill;
  assign bus.bad_color   = r_bad;

endmodule

// File: tb/tb_color_encoder.sv
// Directed checks of the colour encoder plus a palette round-trip sweep.
module tb_color_encoder;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  color_encoder_if ifc();

  color_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] pal [4];
  initial begin
    pal[0] = 12'hF00; pal[1] = 12'h0F0; pal[2] = 12'h00F; pal[3] = 12'hFF0;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [11:0] c);
    ifc.color_in    = c;
    ifc.color_valid = 1'b1;
    tick();
    ifc.color_valid = 1'b0;
  endtask

  task automatic ack();
    ifc.code_ack = 1'b1;
    tick();
    ifc.code_ack = 1'b0;
  endtask

  initial begin
    logic [1:0]  idx [4];
    logic [47:0] sent, got;
    n_vec = 0;
    n_err = 0;
    ifc.color_in    = 12'h000;
    ifc.color_valid = 1'b0;
    ifc.clear       = 1'b0;
    ifc.code_ack    = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_vec",   ifc.code_vec,    8'h00);
    chk("rst_valid", ifc.code_valid,  1'b0);
    chk("rst_fill",  ifc.fill_count,  2'd0);
    chk("rst_bad",   ifc.bad_color,   1'b0);
    chk("rst_ready", ifc.color_ready, 1'b1);

    // basic sequence
    offer(12'hF00); offer(12'h0F0);
    chk("t1_fill2", ifc.fill_count, 2'd2);
    offer(12'h00F);
    chk("t1_valid_early", ifc.code_valid, 1'b0);
    offer(12'hFF0);
    chk("t1_vec",   ifc.code_vec,    8'hE4);
    chk("t1_valid", ifc.code_valid,  1'b1);
    chk("t1_fill",  ifc.fill_count,  2'd0);
    chk("t1_ready", ifc.color_ready, 1'b0);
    ack();
    chk("t1_ack_valid", ifc.code_valid,  1'b0);
    chk("t1_ack_ready", ifc.color_ready, 1'b1);
    chk("t1_ack_vec",   ifc.code_vec,    8'hE4);

    // HOLD ignores offered colours
    offer(12'hFF0); offer(12'hFF0); offer(12'hF00); offer(12'h0F0);
    chk("t2_vec", ifc.code_vec, 8'h4F);
    ifc.color_in = 12'h00F;
    ifc.color_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_ready_hold", ifc.color_ready, 1'b0);
      tick();
      chk("t2_vec_hold",  ifc.code_vec,   8'h4F);
      chk("t2_fill_hold", ifc.fill_count, 2'd0);
    end
    ack();
    chk("t2_ack_valid", ifc.code_valid, 1'b0);
    chk("t2_ack_fill",  ifc.fill_count, 2'd0);
    ifc.color_valid = 1'b0;

    // off-palette colour in mid-sequence
    offer(12'hF00);
    offer(12'h123);
    chk("t3_bad",  ifc.bad_color,  1'b1);
    chk("t3_fill", ifc.fill_count, 2'd1);
    offer(12'h0F0);
    chk("t3_bad_off", ifc.bad_color,  1'b0);
    chk("t3_fill2",   ifc.fill_count, 2'd2);
    offer(12'h456);
    chk("t3_bb1", ifc.bad_color, 1'b1);
    offer(12'hFFF);
    chk("t3_bb2", ifc.bad_color, 1'b1);
    ack();
    chk("t3_ack_fill_ign", ifc.fill_count, 2'd2);
    chk("t3_bad_end",      ifc.bad_color,  1'b0);
    offer(12'h00F); offer(12'hFF0);
    chk("t3_vec",   ifc.code_vec,   8'hE4);
    chk("t3_valid", ifc.code_valid, 1'b1);
    ack();

    // clear in FILL beats a simultaneous offer
    offer(12'h0F0); offer(12'h00F);
    ifc.clear = 1'b1;
    offer(12'hFF0);
    ifc.clear = 1'b0;
    chk("t4_fill",  ifc.fill_count, 2'd0);
    chk("t4_vec",   ifc.code_vec,   8'hE4);
    chk("t4_valid", ifc.code_valid, 1'b0);
    offer(12'hFF0); offer(12'hFF0); offer(12'hFF0); offer(12'hFF0);
    chk("t4_vec_ff", ifc.code_vec,   8'hFF);
    chk("t4_valid2", ifc.code_valid, 1'b1);

    // clear in HOLD discards but retains code_vec
    ifc.clear = 1'b1;
    tick();
    ifc.clear = 1'b0;
    chk("t5_clr_valid", ifc.code_valid,  1'b0);
    chk("t5_clr_ready", ifc.color_ready, 1'b1);
    chk("t5_clr_vec",   ifc.code_vec,    8'hFF);

    // reset during HOLD
    offer(12'h0F0); offer(12'h0F0); offer(12'h0F0); offer(12'h0F0);
    chk("t6_vec", ifc.code_vec, 8'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", ifc.code_valid,  1'b0);
    chk("t6_vec0",  ifc.code_vec,    8'h00);
    chk("t6_fill",  ifc.fill_count,  2'd0);
    chk("t6_ready", ifc.color_ready, 1'b1);

    // palette round trip
    for (int s = 0; s < 1000; s++) begin
      sent = '0;
      for (int k = 0; k < 4; k++) begin
        idx[k] = 2'($urandom_range(0, 3));
        sent[k*12 +: 12] = pal[idx[k]];
        offer(pal[idx[k]]);
      end
      got = '0;
      for (int k = 0; k < 4; k++)
        got[k*12 +: 12] = pal[ifc.code_vec[k*2 +: 2]];
      chk("rt_colors", got, sent);
      if (s % 100 == 0) chk("rt_valid", ifc.code_valid, 1'b1);
      ack();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/color_encoder.md
# color_encoder

Serial colour encoder: accepts 12-bit RGB colours one per handshake, maps each to its 2-bit palette code, and packs four codes into the 8-bit colour-code vector used across the game datapath. It is the inverse of the palette decode path and sits between the input/pattern-capture logic and any block that stores or compares 4-slot colour sequences. Colours outside the 4-entry palette are rejected with a one-cycle error pulse.

## Interface
- COLOR1, 12'hF00, palette entry for code 2'b00 (red)
- COLOR2, 12'h0F0, palette entry for code 2'b01 (green)
- COLOR3, 12'h00F, palette entry for code 2'b10 (blue)
- COLOR4, 12'hFF0, palette entry for code 2'b11 (yellow)

- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- color_in  in  12  RGB colour {R[3:0],G[3:0],B[3:0]}
- color_valid  in  1  color_in is presented
- color_ready  out  1  encoder can accept a colour this cycle
- clear  in  1  synchronous abort of partially filled sequence
- code_ack  in  1  consumer has taken code_vec
- code_vec  out  8  packed codes; slot0 in [1:0], slot1 [3:2], slot2 [5:4], slot3 [7:6]
- code_valid  out  1  code_vec holds a complete sequence
- fill_count  out  2  number of slots filled in current sequence (0-3)
- bad_color  out  1  one-cycle pulse: offered colour not in palette

## Operation
- Two states: FILL, HOLD. Reset state FILL.
- Reset values: code_vec=8'h00, code_valid=0, fill_count=0, bad_color=0; internal pack register=0.
- color_ready = 1 in FILL, 0 in HOLD (combinational from state).
- Accept = color_valid & color_ready. On accept, color_in compared exactly (all 12 bits) against COLOR1..4:
  - match: code written into slot fill_count of pack register; fill_count increments.
  - no match: bad_color=1 next cycle, slot not written, fill_count unchanged. Not a fatal error; state stays FILL.
- Accept of a matching colour when fill_count=3: code_vec loads pack register with slot3 inserted, code_valid=1, fill_count wraps to 0, pack register cleared, state -> HOLD.
- HOLD: code_valid held high, code_vec stable, no colours accepted. code_ack=1 -> code_valid=0, state -> FILL.
- code_vec keeps its last value after ack until the next sequence completes.
- clear (FILL): fill_count=0, pack register cleared; code_vec unchanged; no accept that cycle even if color_valid=1.
- clear (HOLD): code_valid=0, state -> FILL (sequence discarded, code_vec value retained).
- Priority: reset > clear > code_ack > accept.
- Parameters assumed distinct; if duplicated, lowest-numbered match wins.

## Timing
- Encode latency: fourth accepted colour at edge N -> code_valid=1 and new code_vec visible after edge N.
- bad_color asserted the cycle after the rejected offer, for exactly one cycle per rejected offer (back-to-back bad offers give back-to-back pulses).
- Minimum sequence: 4 cycles of accepts + 1 ack cycle; FILL resumes accepting the cycle after code_ack is sampled.
- code_ack while in FILL is ignored. code_ack and color_valid in the same HOLD cycle: ack taken, colour not accepted (ready was 0).
- Reset mid-HOLD or mid-fill: all outputs to reset values next edge, partial data lost.

## Test plan
- Offer F00, 0F0, 00F, FF0 back-to-back -> after 4th edge code_vec=8'hE4, code_valid=1, fill_count=0; code_ack -> code_valid=0 next cycle.
- Offer FF0, FF0, F00, 0F0 -> code_vec=8'h4F; hold color_valid high in HOLD for 5 cycles with 00F -> color_ready=0, nothing accepted, code_vec unchanged.
- Offer F00, 123, 0F0, 00F, FF0 -> bad_color single pulse after 123, fill_count stays 1 across it, final code_vec=8'hE4.
- Offer 0F0, 00F, then clear with color_valid=1 (FF0) -> fill_count=0, FF0 not taken; then FF0×4 -> code_vec=8'hFF.
- Complete a sequence, assert reset during HOLD -> code_valid=0, code_vec=8'h00, fill_count=0, color_ready=1 next cycle.
- Random legal colours over 1000 sequences, output fed to the palette decode path -> reconstructed 48-bit colours equal offered colours in slot order.
